signed_div_seq: RTL and testbench

- Multi-cycle signed/unsigned 32-bit integer divide controller for the Extended DLX execute stage.
- Sequences one shared external two's-complement negation unit through its ports: in_twos driven from neg_in, en from neg_en, out_twos returned on neg_out.
- Steps: operand magnitude conversion, 32-step restoring division, result sign fix-up.
- Gives DIV/DIVU/REM-style instructions a fixed-latency start/busy/done handshake toward the pipeline stall logic.

---
 rtl/signed_div_seq.sv | 191 +++++++++++++++++++
 tb/tb_signed_div_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/signed_div_seq.sv
// signed_div_seq: multi-cycle 32-bit signed/unsigned integer divider.
// Drives one shared external two's-complement negation unit. That unit turns
// the operands into magnitudes, and later applies the sign to the quotient and
// to the remainder. Between those steps it runs a WIDTH-step restoring divide.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, is_signed         request and signedness, sampled only in IDLE
//   dividend, divisor        operands, captured when start is accepted
//   busy, done               busy in every state except IDLE; done pulses one cycle
//   quotient, remainder      registered results
//   div_by_zero              registered flag, set when the divisor is zero
//   neg_in, neg_en, neg_out  operand, enable and result of the shared negation unit
module signed_div_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] neg_in,
  output logic             neg_en,
  input  logic [WIDTH-1:0] neg_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_DIVIDE = 3'd3,
    S_FIX_Q  = 3'd4,
    S_FIX_R  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // r_a holds the dividend, then its magnitude. During DIVIDE it becomes a
  // shift register: dividend bits leave at the top and quotient bits enter at
  // the bottom. After the last step it holds the quotient magnitude.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_a;
  logic             r_sign_b;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_div_zero;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_sub;
  logic             w_fits;
  logic [WIDTH:0]   w_rem_next;

  assign w_div_zero  = (divisor == '0);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

  // One restoring step. The trial is one bit wider than the stored remainder.
  // A borrow therefore appears as the top bit of w_sub, and a 2^31 magnitude
  // never overflows.
  assign w_shift    = {r_rem, r_a[WIDTH-1]};
  assign w_sub      = w_shift - {2'b00, r_b};
  assign w_fits     = ~w_sub[WIDTH+1];
  assign w_rem_next = w_fits ? w_sub[WIDTH:0] : w_shift[WIDTH:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the decoded outputs. neg_in and neg_en depend only on the
  // state and the internal registers.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    neg_in       = '0;
    neg_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_next = w_div_zero ? S_DONE : S_ABS_A;
        end
      end
      S_ABS_A: begin
        neg_in       = r_a;
        neg_en       = r_sign_a;
        w_state_next = S_ABS_B;
      end
      S_ABS_B: begin
        neg_in       = r_b;
        neg_en       = r_sign_b;
        w_state_next = S_DIVIDE;
      end
      S_DIVIDE: begin
        if (r_cnt == CNT_W'(WIDTH - 1)) begin
          w_state_next = S_FIX_Q;
        end
      end
      S_FIX_Q: begin
        neg_in       = r_a;
        neg_en       = r_sign_a ^ r_sign_b;
        w_state_next = S_FIX_R;
      end
      S_FIX_R: begin
        neg_in       = r_rem[WIDTH-1:0];
        neg_en       = r_sign_a;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, magnitude conversion, division, sign fix-up
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a           <= '0;
      r_b           <= '0;
      r_rem         <= '0;
      r_cnt         <= '0;
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a           <= dividend;
            r_b           <= divisor;
            r_sign_a      <= is_signed & dividend[WIDTH-1];
            r_sign_b      <= is_signed & divisor[WIDTH-1];
            r_div_by_zero <= w_div_zero;
            // A zero divisor skips straight to DONE, so its results are
            // loaded here.
            if (w_div_zero) begin
              r_quotient  <= '1;
              r_remainder <= dividend;
            end
          end
        end
        S_ABS_A: begin
          r_a <= neg_out;
        end
        S_ABS_B: begin
          r_b   <= neg_out;
          r_rem <= '0;
          r_cnt <= '0;
        end
        S_DIVIDE: begin
          r_rem <= w_rem_next;
          r_a   <= {r_a[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_FIX_Q: begin
          r_quotient <= neg_out;
        end
        S_FIX_R: begin
          r_remainder <= neg_out;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_seq.sv
// Testbench for signed_div_seq. Stimulus pushes the expected results into a
// scoreboard queue. A separate monitor pops an entry and compares it whenever
// the DUT pulses done. done_cyc is the clock edge on which DONE is entered:
// 36 edges after the accepting edge for a normal divide, and that same edge
// for a zero divisor.
module tb_signed_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic [31:0] neg_in;
  logic        neg_en;
  logic [31:0] neg_out;

  always #5 clk = ~clk;

  // Model of the shared negation unit
  assign neg_out = neg_en ? (~neg_in + 32'd1) : neg_in;

  signed_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .neg_in      (neg_in),
    .neg_en      (neg_en),
    .neg_out     (neg_out)
  );

  typedef struct {
    string       tag;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_quotient"},  64'(quotient),    64'(e.q));
        check({e.tag, "_remainder"}, 64'(remainder),   64'(e.r));
        check({e.tag, "_dbz"},       64'(div_by_zero), 64'(e.dbz));
        check({e.tag, "_done_cyc"},  64'(cyc),         64'(e.done_cyc));
        check({e.tag, "_busy"},      64'(busy),        64'd1);
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic issue(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic push, input logic [31:0] eq,
                       input logic [31:0] er, input logic edbz, output int e0);
    exp_t e;
    wait_idle();
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    if (push) begin
      e.tag = tag; e.q = eq; e.r = er; e.dbz = edbz;
      e.done_cyc = e0 + ((b == 32'd0) ? 0 : 36);
      sb.push_back(e);
    end
  endtask

  // Samples neg_en and busy on the 37 cycles that follow the accepting edge
  task automatic sample_masks(output logic [36:0] en_m, output logic [36:0] busy_m);
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      en_m[k]   = neg_en;
      busy_m[k] = busy;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached with %0d results outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int          e0;
    int          k;
    logic [36:0] en_m;
    logic [36:0] busy_m;
    exp_t        e;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  64'(busy),        64'd0);
    check("rst_done",  64'(done),        64'd0);
    check("rst_q",     64'(quotient),    64'd0);
    check("rst_r",     64'(remainder),   64'd0);
    check("rst_dbz",   64'(div_by_zero), 64'd0);
    check("rst_negen", 64'(neg_en),      64'd0);
    rst = 1'b0;

    // Unsigned: check the busy window and that the negation unit stays idle
    issue("u100_7", 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, e0);
    sample_masks(en_m, busy_m);
    check("u100_7_busy_mask", 64'(busy_m), 64'(37'h1F_FFFF_FFFF));
    check("u100_7_negen_mask", 64'(en_m), 64'd0);
    @(negedge clk);
    check("u100_7_busy_after", 64'(busy), 64'd0);

    // Signed sign matrix. Mask bits are offsets 0=ABS_A, 1=ABS_B, 34=FIX_Q, 35=FIX_R
    issue("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, e0);
    sample_masks(en_m, busy_m);
    check("sm7_2_negen_mask", 64'(en_m), 64'(37'hC_0000_0001));
    issue("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, e0);
    sample_masks(en_m, busy_m);
    check("s7_m2_negen_mask", 64'(en_m), 64'(37'h4_0000_0002));
    issue("sm7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 1'b0, e0);
    sample_masks(en_m, busy_m);
    check("sm7_m2_negen_mask", 64'(en_m), 64'(37'h8_0000_0003));

    // Boundaries
    issue("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, e0);
    issue("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, e0);
    issue("u5_9", 1'b0, 32'd5, 32'd9, 1'b1, 32'd0, 32'd5, 1'b0, e0);
    issue("u_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, e0);
    issue("s_min_2", 1'b1, 32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'd0, 1'b0, e0);

    // Divide by zero, then a valid divide that clears the flag
    issue("dz1234", 1'b0, 32'd1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd1234, 1'b1, e0);
    issue("sm100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, e0);
    issue("dz_m5", 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, e0);

    // A start pulse at offset 10 of an active divide is ignored
    issue("ign100_7", 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, e0);
    repeat (10) @(negedge clk);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    start = 1'b0;

    // start held through done: the second op is accepted on edge E0+38
    wait_idle();
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1;
    e0 = cyc;
    is_signed = 1'b1; dividend = 32'hFFFF_FFCE; divisor = 32'd3;
    e.tag = "held_a"; e.q = 32'd10; e.r = 32'd0; e.dbz = 1'b0; e.done_cyc = e0 + 36;
    sb.push_back(e);
    e.tag = "held_b"; e.q = 32'hFFFF_FFF0; e.r = 32'hFFFF_FFFE; e.dbz = 1'b0;
    e.done_cyc = e0 + 38 + 36;
    sb.push_back(e);
    k = 0;
    while (cyc < e0 + 38 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;

    // Reset at offset 20 aborts the divide; no done pulse may follow
    issue("abort", 1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, e0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy",  64'(busy),        64'd0);
    check("abort_done",  64'(done),        64'd0);
    check("abort_q",     64'(quotient),    64'd0);
    check("abort_r",     64'(remainder),   64'd0);
    check("abort_dbz",   64'(div_by_zero), 64'd0);
    check("abort_negen", 64'(neg_en),      64'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue("post_rst", 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, e0);

    k = 0;
    while (sb.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
